control_unit: RTL and testbench

Hardwired control sequencer that sits directly upstream of `Datapath_P2`. It steps the fetch/execute timing states T0..T7 and drives every datapath control strobe for the currently decoded instruction. It replaces the hand-sequenced stimulus previously used to run single instructions, so the datapath runs programs from memory unattended.

---
 rtl/cpu_pkg.sv | 86 ++++++++
 rtl/control_unit_if.sv | 28 ++
 rtl/control_unit_opcode_decode.sv | 38 +++
 rtl/control_unit.sv | 148 ++++++++++++++
 tb/tb_control_unit.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the hardwired control sequencer.
//   - opcode constants (IR[31:27])
//   - instruction-class enum produced by opcode_decode
//   - one-hot ALU select encoding, order {ADD, SUB, AND, OR}
//   - FSM state encoding for control_unit
//   - ctrl_t: packed bundle of every control strobe, MSB first in port order
package cpu_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01001;
    localparam logic [4:0] OP_ANDI = 5'b01010;
    localparam logic [4:0] OP_ORI  = 5'b01011;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [2:0] {
        CLS_ALU_R, CLS_ALU_I, CLS_LDI, CLS_LD, CLS_ST, CLS_BR, CLS_NOP, CLS_HALT
    } cls_e;

    localparam logic [3:0] SEL_ADD = 4'b1000;
    localparam logic [3:0] SEL_SUB = 4'b0100;
    localparam logic [3:0] SEL_AND = 4'b0010;
    localparam logic [3:0] SEL_OR  = 4'b0001;

    // The ALU op is folded into the T4 state so the op survives past T3
    // without a separate register.
    localparam logic [4:0] S_RST    = 5'd0;
    localparam logic [4:0] S_T0     = 5'd1;
    localparam logic [4:0] S_T1     = 5'd2;
    localparam logic [4:0] S_T2     = 5'd3;
    localparam logic [4:0] S_T3     = 5'd4;
    localparam logic [4:0] S_R4_ADD = 5'd5;
    localparam logic [4:0] S_R4_SUB = 5'd6;
    localparam logic [4:0] S_R4_AND = 5'd7;
    localparam logic [4:0] S_R4_OR  = 5'd8;
    localparam logic [4:0] S_I4_ADD = 5'd9;
    localparam logic [4:0] S_I4_AND = 5'd10;
    localparam logic [4:0] S_I4_OR  = 5'd11;
    localparam logic [4:0] S_WB5    = 5'd12;
    localparam logic [4:0] S_LD4    = 5'd13;
    localparam logic [4:0] S_LD5    = 5'd14;
    localparam logic [4:0] S_LD6    = 5'd15;
    localparam logic [4:0] S_LD7    = 5'd16;
    localparam logic [4:0] S_ST4    = 5'd17;
    localparam logic [4:0] S_ST5    = 5'd18;
    localparam logic [4:0] S_ST6    = 5'd19;
    localparam logic [4:0] S_ST7    = 5'd20;
    localparam logic [4:0] S_BR4    = 5'd21;
    localparam logic [4:0] S_BR5    = 5'd22;
    localparam logic [4:0] S_BR6    = 5'd23;
    localparam logic [4:0] S_HALT   = 5'd24;

    typedef struct packed {
        logic       run;
        logic       pc_out;
        logic       zhi_out;
        logic       zlow_out;
        logic       mdr_out;
        logic       ba_out;
        logic       c_out;
        logic       mar_in;
        logic       z_in;
        logic       pc_in;
        logic       mdr_in;
        logic       ir_in;
        logic       y_in;
        logic       con_in;
        logic       inc_pc;
        logic       read;
        logic       write;
        logic       gra;
        logic       grb;
        logic       grc;
        logic       r_in;
        logic       r_out;
        logic [3:0] alu;    // {ADD, SUB, AND, OR}
    } ctrl_t;

endpackage

// File: rtl/control_unit_if.sv
// control_unit_if: bundle between the control sequencer and Datapath_P2.
//   master (control_unit): inputs IR, BranchMet, Stop; drives Run and all strobes.
//   slave  (datapath):     the reverse.
interface control_unit_if;
    logic [31:0] IR;
    logic        BranchMet, Stop, Run;
    logic        PCout, Zhiout, Zlowout, MDRout, BAout, Cout;
    logic        MARin, Zin, PCin, MDRin, IRin, Yin, CONIn;
    logic        IncPC, Read, Write;
    logic        Gra, Grb, Grc, Rin, Rout;
    logic        ADD, SUB, AND, OR;

    modport master (
        input  IR, BranchMet, Stop,
        output Run, PCout, Zhiout, Zlowout, MDRout, BAout, Cout,
               MARin, Zin, PCin, MDRin, IRin, Yin, CONIn,
               IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout,
               ADD, SUB, AND, OR
    );

    modport slave (
        output IR, BranchMet, Stop,
        input  Run, PCout, Zhiout, Zlowout, MDRout, BAout, Cout,
               MARin, Zin, PCin, MDRin, IRin, Yin, CONIn,
               IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout,
               ADD, SUB, AND, OR
    );
endinterface

// File: rtl/control_unit_opcode_decode.sv
// opcode_decode: combinational opcode -> instruction class + one-hot ALU select.
//   opcode  in  OPW : IR[31:27]
//   cls     out     : instruction class (unknown opcodes map to CLS_NOP)
//   alu_sel out 4   : {ADD,SUB,AND,OR} one-hot, or zero for nop/halt
// Config macro CTRL_BRANCH_EN: when undefined, br decodes as nop.
module opcode_decode
    import cpu_pkg::*;
#(
    parameter int OPW = 5
) (
    input  logic [OPW-1:0] opcode,
    output cls_e           cls,
    output logic [3:0]     alu_sel
);

    always_comb begin
        cls     = CLS_NOP;
        alu_sel = '0;
        case (opcode)
            OPW'(OP_LD):   begin cls = CLS_LD;    alu_sel = SEL_ADD; end
            OPW'(OP_LDI):  begin cls = CLS_LDI;   alu_sel = SEL_ADD; end
            OPW'(OP_ST):   begin cls = CLS_ST;    alu_sel = SEL_ADD; end
            OPW'(OP_ADD):  begin cls = CLS_ALU_R; alu_sel = SEL_ADD; end
            OPW'(OP_SUB):  begin cls = CLS_ALU_R; alu_sel = SEL_SUB; end
            OPW'(OP_AND):  begin cls = CLS_ALU_R; alu_sel = SEL_AND; end
            OPW'(OP_OR):   begin cls = CLS_ALU_R; alu_sel = SEL_OR;  end
            OPW'(OP_ADDI): begin cls = CLS_ALU_I; alu_sel = SEL_ADD; end
            OPW'(OP_ANDI): begin cls = CLS_ALU_I; alu_sel = SEL_AND; end
            OPW'(OP_ORI):  begin cls = CLS_ALU_I; alu_sel = SEL_OR;  end
`ifdef CTRL_BRANCH_EN
            OPW'(OP_BR):   begin cls = CLS_BR;    alu_sel = SEL_ADD; end
`endif
            OPW'(OP_HALT): cls = CLS_HALT;
            default:       cls = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// control_unit: hardwired Moore sequencer (T0..T7) driving Datapath_P2.
//   Clock in : rising-edge clock
//   Clear in : synchronous active-low reset (next state RST)
//   bus      : control_unit_if.master -- IR/BranchMet/Stop in, Run + strobes out
// Config macro CTRL_BRANCH_EN: enables the BR4..BR6 branch sequence; when
// undefined, br runs as nop and CONIn stays 0.
// Stop is only honoured in the final state of an instruction; HALT is left
// only through reset.
module control_unit
    import cpu_pkg::*;
#(
    parameter int OPW = 5
) (
    input  logic           Clock,
    input  logic           Clear,
    control_unit_if.master bus
);

    logic [4:0] state_q, state_d;
    logic [4:0] next_instr;
    cls_e       cls;
    logic [3:0] alu_sel;
    ctrl_t      c;

    opcode_decode #(.OPW(OPW)) u_dec (
        .opcode  (bus.IR[31 -: OPW]),
        .cls     (cls),
        .alu_sel (alu_sel)
    );

    assign next_instr = bus.Stop ? S_HALT : S_T0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST: state_d = S_T0;
            S_T0:  state_d = S_T1;
            S_T1:  state_d = S_T2;
            S_T2:  state_d = S_T3;
            S_T3: begin
                case (cls)
                    CLS_ALU_R: begin
                        case (alu_sel)
                            SEL_SUB: state_d = S_R4_SUB;
                            SEL_AND: state_d = S_R4_AND;
                            SEL_OR:  state_d = S_R4_OR;
                            default: state_d = S_R4_ADD;
                        endcase
                    end
                    CLS_ALU_I: begin
                        case (alu_sel)
                            SEL_AND: state_d = S_I4_AND;
                            SEL_OR:  state_d = S_I4_OR;
                            default: state_d = S_I4_ADD;
                        endcase
                    end
                    CLS_LDI:  state_d = S_I4_ADD;  // ldi T4 is addi's T4
                    CLS_LD:   state_d = S_LD4;
                    CLS_ST:   state_d = S_ST4;
`ifdef CTRL_BRANCH_EN
                    CLS_BR:   state_d = S_BR4;
`endif
                    CLS_HALT: state_d = S_HALT;
                    default:  state_d = next_instr; // nop ends in T3
                endcase
            end
            S_R4_ADD, S_R4_SUB, S_R4_AND, S_R4_OR,
            S_I4_ADD, S_I4_AND, S_I4_OR: state_d = S_WB5;
            S_WB5: state_d = next_instr;
            S_LD4: state_d = S_LD5;
            S_LD5: state_d = S_LD6;
            S_LD6: state_d = S_LD7;
            S_LD7: state_d = next_instr;
            S_ST4: state_d = S_ST5;
            S_ST5: state_d = S_ST6;
            S_ST6: state_d = S_ST7;
            S_ST7: state_d = next_instr;
`ifdef CTRL_BRANCH_EN
            S_BR4: state_d = S_BR5;
            S_BR5: state_d = S_BR6;
            S_BR6: state_d = next_instr;
`endif
            S_HALT: state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Clear) state_q <= S_RST;
        else        state_q <= state_d;
    end

    // Output decode: state only, except T3 (class from the freshly loaded IR)
    // and BR6 (PCin follows BranchMet).
    always_comb begin
        c     = '0;
        c.run = (state_q != S_RST) && (state_q != S_HALT);
        case (state_q)
            S_T0: begin c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; c.z_in = 1'b1; end
            S_T1: begin c.zlow_out = 1'b1; c.pc_in = 1'b1; c.read = 1'b1; c.mdr_in = 1'b1; end
            S_T2: begin c.mdr_out = 1'b1; c.ir_in = 1'b1; end
            S_T3: begin
                case (cls)
                    CLS_ALU_R, CLS_ALU_I: begin c.grb = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1; end
                    CLS_LDI, CLS_LD, CLS_ST: begin c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1; end
`ifdef CTRL_BRANCH_EN
                    CLS_BR: begin c.gra = 1'b1; c.r_out = 1'b1; c.con_in = 1'b1; end
`endif
                    default: ;
                endcase
            end
            S_R4_ADD, S_R4_SUB, S_R4_AND, S_R4_OR: begin
                c.grc = 1'b1; c.r_out = 1'b1; c.z_in = 1'b1;
            end
            S_I4_ADD, S_I4_AND, S_I4_OR, S_LD4, S_ST4, S_BR5: begin
                c.c_out = 1'b1; c.z_in = 1'b1;
            end
            S_WB5, S_LD7: begin
                c.zlow_out = (state_q == S_WB5);
                c.mdr_out  = (state_q == S_LD7);
                c.gra = 1'b1; c.r_in = 1'b1;
            end
            S_LD5, S_ST5: begin c.zlow_out = 1'b1; c.mar_in = 1'b1; end
            S_LD6: begin c.read = 1'b1; c.mdr_in = 1'b1; end
            S_ST6: begin c.gra = 1'b1; c.r_out = 1'b1; c.mdr_in = 1'b1; end
            S_ST7: c.write = 1'b1;
`ifdef CTRL_BRANCH_EN
            S_BR4: begin c.pc_out = 1'b1; c.y_in = 1'b1; end
            S_BR6: begin c.zlow_out = 1'b1; c.pc_in = bus.BranchMet; end
`endif
            default: ;
        endcase

        case (state_q)
            S_R4_ADD, S_I4_ADD, S_LD4, S_ST4, S_BR5: c.alu = SEL_ADD;
            S_R4_SUB:                                c.alu = SEL_SUB;
            S_R4_AND, S_I4_AND:                      c.alu = SEL_AND;
            S_R4_OR,  S_I4_OR:                       c.alu = SEL_OR;
            default:                                 c.alu = '0;
        endcase
    end

    assign {bus.Run, bus.PCout, bus.Zhiout, bus.Zlowout, bus.MDRout, bus.BAout,
            bus.Cout, bus.MARin, bus.Zin, bus.PCin, bus.MDRin, bus.IRin, bus.Yin,
            bus.CONIn, bus.IncPC, bus.Read, bus.Write, bus.Gra, bus.Grb, bus.Grc,
            bus.Rin, bus.Rout, bus.ADD, bus.SUB, bus.AND, bus.OR} = c;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized instruction stream checked cycle by cycle
// against a per-instruction list of expected strobe sets, plus directed
// halt / Stop / mid-instruction reset cases.
module tb_control_unit;

    typedef logic [25:0] vec_t;

    localparam vec_t RUN    = vec_t'(1) << 25;
    localparam vec_t PCOUT  = vec_t'(1) << 24;
    localparam vec_t ZLOW   = vec_t'(1) << 22;
    localparam vec_t MDROUT = vec_t'(1) << 21;
    localparam vec_t BAOUT  = vec_t'(1) << 20;
    localparam vec_t COUT   = vec_t'(1) << 19;
    localparam vec_t MARIN  = vec_t'(1) << 18;
    localparam vec_t ZIN    = vec_t'(1) << 17;
    localparam vec_t PCIN   = vec_t'(1) << 16;
    localparam vec_t MDRIN  = vec_t'(1) << 15;
    localparam vec_t IRIN   = vec_t'(1) << 14;
    localparam vec_t YIN    = vec_t'(1) << 13;
    localparam vec_t CONIN  = vec_t'(1) << 12;
    localparam vec_t INCPC  = vec_t'(1) << 11;
    localparam vec_t READ   = vec_t'(1) << 10;
    localparam vec_t WRITE  = vec_t'(1) << 9;
    localparam vec_t GRA    = vec_t'(1) << 8;
    localparam vec_t GRB    = vec_t'(1) << 7;
    localparam vec_t GRC    = vec_t'(1) << 6;
    localparam vec_t RIN    = vec_t'(1) << 5;
    localparam vec_t ROUT   = vec_t'(1) << 4;
    localparam vec_t A_ADD  = vec_t'(1) << 3;
    localparam vec_t A_SUB  = vec_t'(1) << 2;
    localparam vec_t A_AND  = vec_t'(1) << 1;
    localparam vec_t A_OR   = vec_t'(1) << 0;

    logic Clock = 1'b0;
    logic Clear = 1'b0;
    always #5 Clock = ~Clock;

    control_unit_if bus ();
    control_unit #(.OPW(5)) dut (.Clock(Clock), .Clear(Clear), .bus(bus));

    vec_t obs;
    assign obs = {bus.Run, bus.PCout, bus.Zhiout, bus.Zlowout, bus.MDRout, bus.BAout,
                  bus.Cout, bus.MARin, bus.Zin, bus.PCin, bus.MDRin, bus.IRin, bus.Yin,
                  bus.CONIn, bus.IncPC, bus.Read, bus.Write, bus.Gra, bus.Grb, bus.Grc,
                  bus.Rin, bus.Rout, bus.ADD, bus.SUB, bus.AND, bus.OR};

    int   vecs = 0;
    int   errs = 0;
    vec_t exp_q[$];

    task automatic chk(input string tag, input vec_t got, input vec_t exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void p(input vec_t v);
        exp_q.push_back(v | RUN);
    endfunction

    // Reference: the strobe set of every cycle of one instruction, T0 onward.
    function automatic void build(input logic [31:0] ir, input bit bm);
        logic [4:0] op;
        vec_t       sel;
        op = ir[31:27];
        exp_q.delete();
        p(PCOUT | MARIN | INCPC | ZIN);
        p(ZLOW | PCIN | READ | MDRIN);
        p(MDROUT | IRIN);
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
                sel = (op == 5'b00011) ? A_ADD : (op == 5'b00100) ? A_SUB :
                      (op == 5'b00101) ? A_AND : A_OR;
                p(GRB | ROUT | YIN);
                p(GRC | ROUT | sel | ZIN);
                p(ZLOW | GRA | RIN);
            end
            5'b01001, 5'b01010, 5'b01011: begin
                sel = (op == 5'b01001) ? A_ADD : (op == 5'b01010) ? A_AND : A_OR;
                p(GRB | ROUT | YIN);
                p(COUT | sel | ZIN);
                p(ZLOW | GRA | RIN);
            end
            5'b00001: begin
                p(GRB | BAOUT | YIN);
                p(COUT | A_ADD | ZIN);
                p(ZLOW | GRA | RIN);
            end
            5'b00000: begin
                p(GRB | BAOUT | YIN);
                p(COUT | A_ADD | ZIN);
                p(ZLOW | MARIN);
                p(READ | MDRIN);
                p(MDROUT | GRA | RIN);
            end
            5'b00010: begin
                p(GRB | BAOUT | YIN);
                p(COUT | A_ADD | ZIN);
                p(ZLOW | MARIN);
                p(GRA | ROUT | MDRIN);
                p(WRITE);
            end
`ifdef CTRL_BRANCH_EN
            5'b10010: begin
                p(GRA | ROUT | CONIN);
                p(PCOUT | YIN);
                p(COUT | A_ADD | ZIN);
                p(ZLOW | (bm ? PCIN : '0));
            end
`endif
            default: p('0);   // nop, halt, unknown (and br when disabled)
        endcase
    endfunction

    // Runs one instruction from T0; IR is loaded during T2 (garbage before),
    // Stop is random except in the final state. abort_at pulls Clear low
    // during that cycle and returns.
    task automatic run_instr(input string name, input logic [31:0] ir, input bit bm,
                             input bit stop, input int abort_at);
        int last;
        build(ir, bm);
        last = exp_q.size() - 1;
        for (int i = 0; i <= last; i++) begin
            @(posedge Clock); #1;
            if (i == 0) bus.IR = $urandom;
            if (i == 2) bus.IR = ir;
            bus.Stop      = (i == last) ? stop : 1'($urandom);
            bus.BranchMet = (i == last) ? bm   : 1'($urandom);
            if (i == abort_at) Clear = 1'b0;
            @(negedge Clock);
            chk($sformatf("%s ir=%h c%0d", name, ir, i), obs, exp_q[i]);
            if (i == abort_at) return;
        end
    endtask

    task automatic do_reset();
        Clear    = 1'b0;
        bus.Stop = 1'b0;
        repeat (2) begin
            @(posedge Clock);
            @(negedge Clock);
            chk("reset", obs, '0);
        end
        Clear = 1'b1;
    endtask

    task automatic chk_halt(input int n);
        repeat (n) begin
            @(posedge Clock); #1;
            bus.Stop = 1'($urandom);
            @(negedge Clock);
            chk("halt", obs, '0);
        end
    endtask

    logic [4:0] ops [12] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
                             5'b00110, 5'b01001, 5'b01010, 5'b01011, 5'b10010, 5'b11010};

    function automatic logic [31:0] rnd_ir(input bit allow_halt);
        logic [4:0] op;
        if ($urandom_range(0, 4) == 0) op = 5'($urandom);
        else                           op = ops[$urandom_range(0, 11)];
        if (!allow_halt && op == 5'b11011) op = 5'b11010;
        return {op, 27'($urandom)};
    endfunction

    initial begin
        bus.IR = '0; bus.Stop = 1'b0; bus.BranchMet = 1'b0;
        do_reset();

        run_instr("ori", 32'h5908_0023, 1'b0, 1'b0, -1);
        run_instr("ld",  32'h0080_0000, 1'b0, 1'b0, -1);
        run_instr("st",  32'h1080_0000, 1'b0, 1'b0, -1);
        run_instr("br1", 32'h9000_0010, 1'b1, 1'b0, -1);
        run_instr("br0", 32'h9000_0010, 1'b0, 1'b0, -1);

        for (int n = 0; n < 80; n++)
            run_instr("rnd", rnd_ir(1'b0), 1'($urandom), 1'b0, -1);

        run_instr("halt", 32'hD800_0000, 1'b0, 1'b0, -1);
        chk_halt(10);
        do_reset();

        run_instr("ld_abort", 32'h0080_0000, 1'b0, 1'b0, 6);
        do_reset();

        run_instr("add_stop", 32'h1800_0000, 1'b0, 1'b1, -1);
        chk_halt(3);
        do_reset();

        for (int n = 0; n < 8; n++) begin
            run_instr("rnd_stop", rnd_ir(1'b1), 1'($urandom), 1'b1, -1);
            chk_halt(2);
            do_reset();
        end

        run_instr("ori_post", 32'h5908_0023, 1'b0, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
